// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC owner and instruction-memory req/ack fetch stage feeding decode.
// Ports:
//   clk, reset         clock (rising edge), asynchronous active-high reset
//   pc_redirect_i      one-cycle pulse loading pc_target_i as the next fetch address
//   pc_target_i        branch/jump target
//   stall_i            downstream not accepting the presented instruction
//   imem_req_o         memory request, held with imem_addr_o until imem_ack_i
//   imem_addr_o        request address
//   imem_ack_i         response valid (only meaningful while imem_req_o=1)
//   imem_data_i        instruction word, valid with imem_ack_i
//   Instruction_bus_o  registered instruction word
//   op_o               opcode field Instruction_bus_o[6:0]
//   pc_o               address of the instruction on Instruction_bus_o
//   valid_o            Instruction_bus_o, op_o and pc_o are meaningful
//   misalign_o         (FETCH_MISALIGN_CHECK_EN only) sticky misaligned-redirect flag
// Macro FETCH_MISALIGN_CHECK_EN: reject misaligned redirects and flag them instead of
// silently clearing target bits [1:0].
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0040_0000,
    parameter int          DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pc_redirect_i,
    input  logic [DATA_WIDTH-1:0] pc_target_i,
    input  logic                  stall_i,
    output logic                  imem_req_o,
    output logic [DATA_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_ack_i,
    input  logic [DATA_WIDTH-1:0] imem_data_i,
    output logic [DATA_WIDTH-1:0] Instruction_bus_o,
    output logic [6:0]            op_o,
    output logic [DATA_WIDTH-1:0] pc_o,
`ifdef FETCH_MISALIGN_CHECK_EN
    output logic                  misalign_o,
`endif
    output logic                  valid_o
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP, S_OUT} state_t;
    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [DATA_WIDTH-1:0] pc_out_q, pc_out_d;
    logic                  valid_q, valid_d;
    logic                  redir;
    logic [DATA_WIDTH-1:0] tgt;

    assign tgt = pc_target_i & ~DATA_WIDTH'(3);

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign_q, misalign_d;
    logic bad_target;
    assign bad_target = pc_redirect_i && (pc_target_i[1:0] != 2'b00);
    assign redir      = pc_redirect_i && !bad_target;
    assign misalign_d = misalign_q | bad_target;
    assign misalign_o = misalign_q;
`else
    assign redir = pc_redirect_i;
`endif

    always_comb begin
        state_d  = state_q;
        pc_d     = redir ? tgt : pc_q;
        addr_d   = addr_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;
        case (state_q)
            S_IDLE: begin
                addr_d  = redir ? tgt : pc_q;
                state_d = S_REQ;
            end
            S_REQ: begin
                // a redirect kills the outstanding fetch; if its ack is still pending it must be drained
                if (redir) state_d = imem_ack_i ? S_IDLE : S_DROP;
                else if (imem_ack_i) begin
                    instr_d  = imem_data_i;
                    pc_out_d = addr_q;
                    valid_d  = 1'b1;
                    pc_d     = addr_q + DATA_WIDTH'(4);
                    state_d  = S_OUT;
                end
            end
            S_DROP: state_d = imem_ack_i ? S_IDLE : S_DROP;
            S_OUT: begin
                if (redir) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end else if (!stall_i) begin
                    valid_d = 1'b0;
                    addr_d  = pc_q;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            addr_q   <= RESET_PC;
            instr_q  <= '0;
            pc_out_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) misalign_q <= 1'b0;
        else misalign_q <= misalign_d;
    end
`endif

    assign imem_req_o        = (state_q == S_REQ) || (state_q == S_DROP);
    assign imem_addr_o       = addr_q;
    assign Instruction_bus_o = instr_q;
    assign op_o              = instr_q[6:0];
    assign pc_o              = pc_out_q;
    assign valid_o           = valid_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: scoreboard bench for instruction_fetch_unit with a wait-state memory model.
module tb_instruction_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pc_redirect_i = 1'b0;
    logic [31:0] pc_target_i = '0;
    logic        stall_i = 1'b1;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_data_i = '0;
    logic [31:0] Instruction_bus_o;
    logic [6:0]  op_o;
    logic [31:0] pc_o;
    logic        valid_o;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        misalign_o;
`endif

    instruction_fetch_unit dut (
        .clk(clk), .reset(reset),
        .pc_redirect_i(pc_redirect_i), .pc_target_i(pc_target_i), .stall_i(stall_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i),
        .Instruction_bus_o(Instruction_bus_o), .op_o(op_o), .pc_o(pc_o),
`ifdef FETCH_MISALIGN_CHECK_EN
        .misalign_o(misalign_o),
`endif
        .valid_o(valid_o)
    );

    always #5 clk = ~clk;

    typedef struct {logic [31:0] pc; logic [31:0] instr;} exp_t;
    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int waits = 0;
    int req_cycles = 0;
    int last_req_cycles = 0;
    logic mem_en = 1'b1;
    logic late_ack = 1'b0;
    logic [31:0] busy_addr = '0;
    logic valid_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a == RST_PC) ? 32'h0050_0093 : (a ^ 32'h5A5A_0000);
    endfunction

    task automatic push(input logic [31:0] a);
        exp_t e;
        e.pc = a;
        e.instr = mem(a);
        sb.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        stall_i = 1'b1;
        check("drain", sb.size(), 0);
        sb.delete();
    endtask

    // memory: acks after `waits` wait states, checks address stability while requested
    always @(negedge clk) begin
        if (!mem_en) begin
            imem_ack_i = late_ack;
            imem_data_i = 32'hDEAD_BEEF;
            req_cycles = 0;
        end else if (imem_req_o) begin
            if (req_cycles == 0) busy_addr = imem_addr_o;
            else check("addr_stable", imem_addr_o, busy_addr);
            req_cycles++;
            imem_ack_i = (req_cycles > waits);
            imem_data_i = mem(imem_addr_o);
        end else begin
            if (req_cycles != 0) last_req_cycles = req_cycles;
            req_cycles = 0;
            imem_ack_i = 1'b0;
        end
    end

    // monitor: each rising valid_o is one delivered instruction
    always @(negedge clk) begin
        if (valid_o && !valid_prev) begin
            if (sb.size() == 0) check("unexpected_valid", pc_o, 32'hFFFF_FFFF);
            else begin
                exp_t e;
                e = sb.pop_front();
                check("pc_o", pc_o, e.pc);
                check("instr", Instruction_bus_o, e.instr);
                check("op", {25'b0, op_o}, {25'b0, e.instr[6:0]});
            end
        end
        valid_prev = valid_o;
    end

    initial begin
        #1 reset = 1'b1;
        cyc(2);
        check("rst_req", imem_req_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_addr", imem_addr_o, RST_PC);
        check("rst_bus", Instruction_bus_o, 0);
        check("rst_op", {25'b0, op_o}, 0);
        check("rst_pc_o", pc_o, 0);
        reset = 1'b0;
        push(RST_PC);
        cyc(1);
        check("req_rise", imem_req_o, 1);
        check("first_addr", imem_addr_o, RST_PC);
        cyc(1);
        check("valid_latency", valid_o, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            check("stall_valid", valid_o, 1);
            check("stall_pc_o", pc_o, RST_PC);
            check("stall_bus", Instruction_bus_o, 32'h0050_0093);
            check("stall_req", imem_req_o, 0);
        end
        check("sb_first", sb.size(), 0);
        push(32'h0040_0004);
        stall_i = 1'b0;
        cyc(1);
        check("next_addr", imem_addr_o, 32'h0040_0004);
        check("next_req", imem_req_o, 1);
        drain(50);

        waits = 5;
        push(32'h0040_0008);
        stall_i = 1'b0;
        drain(100);
        check("wait_req_cycles", last_req_cycles, 6);

        stall_i = 1'b0;
        cyc(1);
        check("wait_addr", imem_addr_o, 32'h0040_000C);
        push(32'h0040_0100);
        cyc(2);
        pc_redirect_i = 1'b1;
        pc_target_i = 32'h0040_0100;
        cyc(1);
        pc_redirect_i = 1'b0;
        check("drop_req", imem_req_o, 1);
        check("drop_addr", imem_addr_o, 32'h0040_000C);
        check("drop_valid", valid_o, 0);
        drain(100);

        waits = 0;
        stall_i = 1'b0;
        cyc(1);
        check("same_req", imem_req_o, 1);
        pc_redirect_i = 1'b1;
        pc_target_i = 32'h0040_0102;
`ifdef FETCH_MISALIGN_CHECK_EN
        push(32'h0040_0104);
`else
        push(32'h0040_0100);
`endif
        cyc(1);
        pc_redirect_i = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        check("same_valid", valid_o, 1);
        check("misalign", misalign_o, 1);
`else
        check("same_valid", valid_o, 0);
`endif
        drain(50);

        push(32'h0040_0200);
        pc_redirect_i = 1'b1;
        pc_target_i = 32'h0040_0200;
        cyc(1);
        pc_redirect_i = 1'b0;
        check("redir_out_valid", valid_o, 0);
        drain(50);

        push(32'hFFFF_FFFC);
        pc_redirect_i = 1'b1;
        pc_target_i = 32'hFFFF_FFFC;
        cyc(1);
        pc_redirect_i = 1'b0;
        drain(50);
        push(32'h0000_0000);
        stall_i = 1'b0;
        cyc(1);
        check("wrap_addr", imem_addr_o, 32'h0000_0000);
        drain(50);

        waits = 10;
        stall_i = 1'b0;
        cyc(3);
        check("pre_rst_req", imem_req_o, 1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_req", imem_req_o, 0);
        check("async_rst_valid", valid_o, 0);
        mem_en = 1'b0;
        late_ack = 1'b1;
        cyc(1);
        late_ack = 1'b0;
        check("late_ack_valid", valid_o, 0);
        check("late_ack_req", imem_req_o, 0);
        cyc(1);
        mem_en = 1'b1;
        waits = 0;
        stall_i = 1'b1;
        push(RST_PC);
        reset = 1'b0;
        cyc(1);
        check("restart_addr", imem_addr_o, RST_PC);
        check("restart_req", imem_req_o, 1);
        drain(50);
`ifdef FETCH_MISALIGN_CHECK_EN
        check("misalign_cleared", misalign_o, 0);
`endif
        cyc(3);
        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
